chan_thresh_decoder: RTL

- Receive side of the dual-threshold comparison path. The PWM threshold generator sets the VIL and VIH reference levels; this block takes the two asynchronous comparator outputs for one channel and turns them into a debounced rail level.
- Rail levels are LOW, MID or HIGH.
- Tracks the last rail reached, so a rise or fall strobe fires only on a true rail-to-rail crossing; a brief excursion into mid rail does not produce an edge.
- Flags illegal comparator combinations as an error.
- One instance per channel; outputs feed trigger and capture logic.

---
 rtl/chan_pkg.sv | 37 +++
 rtl/sync_ff.sv | 25 ++
 rtl/chan_thresh_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
// Shared types for the dual-threshold channel decoder: committed rail
// levels, decoder FSM states, and the raw comparator-pair classifier.
package chan_pkg;

    typedef enum logic [1:0] {
        LVL_LOW  = 2'b00,
        LVL_MID  = 2'b01,
        LVL_HIGH = 2'b11
    } level_t;

    typedef enum logic [2:0] {
        INIT,
        LOW,
        MID_L,
        MID_H,
        HIGH
    } dec_state_t;

    // Map a synchronized (H,L) comparator pair onto a rail class.
    // The (1,0) pair cannot occur physically (above VIH but below VIL),
    // so it is treated as mid rail and flagged separately by the caller.
    function automatic level_t classify(input logic h, input logic l);
        level_t cls;
        case ({h, l})
            2'b11:   cls = LVL_HIGH;
            2'b00:   cls = LVL_LOW;
            default: cls = LVL_MID;
        endcase
        return cls;
    endfunction

    // True for the physically impossible above-VIH-but-below-VIL pair.
    function automatic logic is_illegal(input logic h, input logic l);
        return h & ~l;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for an asynchronous input.
// Depth is set by STAGES (at least 2); the last flop drives q.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/chan_thresh_decoder.sv
// Per-channel receive decoder for the VIL/VIH comparator pair.
// Synchronizes both comparator outputs, debounces the raw rail class,
// and tracks the last rail reached so rise/fall only strobe on a true
// rail-to-rail crossing. Illegal comparator pairs raise a sticky error.
module chan_thresh_decoder
    import chan_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 4,
    parameter int CNT_W       = $clog2(DB_CNT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CH_H,
    input  logic       CH_L,
    input  logic       smpl_en,
    input  logic       clr_err,
    output logic [1:0] level,
    output logic       rise,
    output logic       fall,
    output logic       err
);

    logic             h_sync;
    logic             l_sync;
    level_t           raw_cls;
    logic             raw_illegal;

    level_t           cand;
    level_t           cand_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    dec_state_t       state;
    dec_state_t       state_nxt;
    level_t           cur_level;
    logic             commit;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             err_nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_h (
        .clk (clk),
        .rst (rst),
        .d   (CH_H),
        .q   (h_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_l (
        .clk (clk),
        .rst (rst),
        .d   (CH_L),
        .q   (l_sync)
    );

    assign raw_cls     = classify(h_sync, l_sync);
    assign raw_illegal = is_illegal(h_sync, l_sync);

    // Debounce: restart the count on a new raw class, otherwise count up to saturation.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (smpl_en) begin
            if (raw_cls != cand) begin
                cand_nxt = raw_cls;
                cnt_nxt  = CNT_W'(1);
            end else if (cnt < CNT_W'(DB_CNT)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Commit is taken on the edge where the count reaches DB_CNT so the level
    // updates on that same edge; a saturated count on the committed class is inert.
    assign commit = smpl_en && (cnt_nxt == CNT_W'(DB_CNT)) && (cand_nxt != cur_level);

    // Decoder FSM next state and strobes; mid-rail states remember the last rail.
    always_comb begin
        state_nxt = state;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (commit) begin
            case (state)
                INIT: begin
                    if (cand_nxt == LVL_LOW)       state_nxt = LOW;
                    else if (cand_nxt == LVL_HIGH) state_nxt = HIGH;
                end
                LOW: begin
                    if (cand_nxt == LVL_MID) begin
                        state_nxt = MID_L;
                    end else if (cand_nxt == LVL_HIGH) begin
                        state_nxt = HIGH;
                        rise_nxt  = 1'b1;
                    end
                end
                MID_L: begin
                    if (cand_nxt == LVL_HIGH) begin
                        state_nxt = HIGH;
                        rise_nxt  = 1'b1;
                    end else if (cand_nxt == LVL_LOW) begin
                        state_nxt = LOW;
                    end
                end
                HIGH: begin
                    if (cand_nxt == LVL_MID) begin
                        state_nxt = MID_H;
                    end else if (cand_nxt == LVL_LOW) begin
                        state_nxt = LOW;
                        fall_nxt  = 1'b1;
                    end
                end
                MID_H: begin
                    if (cand_nxt == LVL_LOW) begin
                        state_nxt = LOW;
                        fall_nxt  = 1'b1;
                    end else if (cand_nxt == LVL_HIGH) begin
                        state_nxt = HIGH;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    // Sticky error: a qualified illegal sample wins over a same-cycle clear.
    always_comb begin
        err_nxt = err;
        if (smpl_en && raw_illegal) begin
            err_nxt = 1'b1;
        end else if (clr_err) begin
            err_nxt = 1'b0;
        end
    end

    // State, debounce and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cand  <= LVL_MID;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            err   <= err_nxt;
        end
    end

    // Committed level is a pure decode of the registered state.
    always_comb begin
        cur_level = LVL_MID;
        case (state)
            LOW:     cur_level = LVL_LOW;
            HIGH:    cur_level = LVL_HIGH;
            default: cur_level = LVL_MID;
        endcase
    end

    assign level = cur_level;

endmodule
